// File: rtl/mem_axi_pkg.sv
// mem_axi_pkg: shared types and constants for mem_axi_arbiter.
//   state_t  - arbiter FSM states
//   owner_t  - which sram-like requester owns the outstanding transaction
//   ID_*     - AXI transaction IDs per requester
//   BURST_INCR - burst type driven on ar/aw (single beat, so only nominal)
package mem_axi_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    RD_ADDR      = 3'd1,
    RD_DATA      = 3'd2,
    WR_ADDR_DATA = 3'd3,
    WR_RESP      = 3'd4
  } state_t;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_t;

  localparam logic [3:0] ID_INST    = 4'd0;
  localparam logic [3:0] ID_DATA    = 4'd1;
  localparam logic [1:0] BURST_INCR = 2'b01;

  // sram size (0/1/2 = byte/half/word) maps directly onto AXI size.
  function automatic logic [2:0] axi_size(input logic [1:0] sram_size);
    return {1'b0, sram_size};
  endfunction

endpackage

// File: rtl/mem_axi_arbiter.sv
// mem_axi_arbiter: shares one single-beat AXI master between the instruction
// fetch and data sram-like ports, one outstanding transaction at a time.
// Ports:
//   clk, reset              - clock, asynchronous active-high reset
//   inst_sram_* / data_sram_* - sram-like requesters (req/wr/size/wstrb/addr/
//                             wdata in; addr_ok/data_ok/rdata out)
//   ar*, r*, aw*, w*, b*    - AXI master channels; fixed fields are constants
// The data port wins any tie in IDLE. addr_ok is only ever raised in IDLE.
module mem_axi_arbiter
  import mem_axi_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  // instruction requester
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  // data requester
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  // read address channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // read data channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // write address channel
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // write data channel
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // write response channel
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  state_t      state_reg;
  owner_t      owner_reg;
  logic        wr_reg;
  logic [1:0]  size_reg;
  logic [31:0] addr_reg;
  logic [3:0]  wstrb_reg;
  logic [31:0] wdata_reg;
  logic        arvalid_reg, awvalid_reg, wvalid_reg;
  logic        aw_done_reg, w_done_reg;

  // Grant depends only on req and state, never on AXI inputs.
  logic grant_data, grant_inst;
  assign grant_data = (state_reg == IDLE) && data_sram_req;
  assign grant_inst = (state_reg == IDLE) && !data_sram_req && inst_sram_req;

  assign data_sram_addr_ok = grant_data;
  assign inst_sram_addr_ok = grant_inst;

  // Payload of whichever port is being granted this cycle.
  logic        sel_wr;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_wstrb;
  assign sel_wr    = grant_data ? data_sram_wr    : inst_sram_wr;
  assign sel_size  = grant_data ? data_sram_size  : inst_sram_size;
  assign sel_addr  = grant_data ? data_sram_addr  : inst_sram_addr;
  assign sel_wdata = grant_data ? data_sram_wdata : inst_sram_wdata;
  assign sel_wstrb = grant_data ? data_sram_wstrb : inst_sram_wstrb;

  // A channel counts as finished if it completed earlier or handshakes now.
  logic aw_fin, w_fin;
  assign aw_fin = aw_done_reg || (awvalid_reg && awready);
  assign w_fin  = w_done_reg  || (wvalid_reg  && wready);

  // Completion is combinational from rvalid/bvalid.
  logic xfer_done;
  assign xfer_done = wr_reg ? ((state_reg == WR_RESP) && bvalid)
                            : ((state_reg == RD_DATA) && rvalid);

  assign data_sram_data_ok = xfer_done && (owner_reg == OWNER_DATA);
  assign inst_sram_data_ok = xfer_done && (owner_reg == OWNER_INST);
  assign data_sram_rdata   = rdata;
  assign inst_sram_rdata   = rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      owner_reg   <= OWNER_INST;
      wr_reg      <= 1'b0;
      size_reg    <= 2'd0;
      addr_reg    <= 32'd0;
      wstrb_reg   <= 4'd0;
      wdata_reg   <= 32'd0;
      arvalid_reg <= 1'b0;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_data || grant_inst) begin
            owner_reg <= grant_data ? OWNER_DATA : OWNER_INST;
            wr_reg    <= sel_wr;
            size_reg  <= sel_size;
            addr_reg  <= sel_addr;
            wstrb_reg <= sel_wstrb;
            wdata_reg <= sel_wdata;
            if (sel_wr) begin
              state_reg   <= WR_ADDR_DATA;
              awvalid_reg <= 1'b1;
              wvalid_reg  <= 1'b1;
            end else begin
              state_reg   <= RD_ADDR;
              arvalid_reg <= 1'b1;
            end
          end
        end
        RD_ADDR: begin
          if (arready) begin
            arvalid_reg <= 1'b0;
            state_reg   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rvalid) state_reg <= IDLE;
        end
        WR_ADDR_DATA: begin
          if (awvalid_reg && awready) begin
            awvalid_reg <= 1'b0;
            aw_done_reg <= 1'b1;
          end
          if (wvalid_reg && wready) begin
            wvalid_reg <= 1'b0;
            w_done_reg <= 1'b1;
          end
          // Later assignments win: flags are cleared for the next write.
          if (aw_fin && w_fin) begin
            state_reg   <= WR_RESP;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
          end
        end
        WR_RESP: begin
          if (bvalid) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Read channels
  assign arid    = (owner_reg == OWNER_DATA) ? ID_DATA : ID_INST;
  assign araddr  = addr_reg;
  assign arlen   = 8'd0;
  assign arsize  = axi_size(size_reg);
  assign arburst = BURST_INCR;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = arvalid_reg;
  assign rready  = (state_reg == RD_DATA);

  // Write channels
  assign awid    = ID_DATA;
  assign awaddr  = addr_reg;
  assign awlen   = 8'd0;
  assign awsize  = axi_size(size_reg);
  assign awburst = BURST_INCR;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = awvalid_reg;
  assign wid     = ID_DATA;
  assign wdata   = wdata_reg;
  assign wstrb   = wstrb_reg;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_reg;
  assign bready  = (state_reg == WR_RESP);

  // Single outstanding transaction: IDs, response codes and rlast carry no
  // information the arbiter needs.
  logic unused_axi_inputs;
  assign unused_axi_inputs = ^{rid, rresp, rlast, bid, bresp};

endmodule

// File: tb/tb_mem_axi_arbiter.sv
// Testbench for mem_axi_arbiter: directed stimulus with a scoreboard of
// expected completions (owner and read data) checked when data_ok fires.
module tb_mem_axi_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid, awid, wid, rid, bid, arcache, awcache, wstrb;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  mem_axi_arbiter dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        owner_data; // 1 = data port, 0 = inst port
    logic        is_read;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  // Scoreboard side: every data_ok pops one expected completion.
  always @(negedge clk) begin
    if (!reset && (inst_sram_data_ok || data_sram_data_ok)) begin
      if (sb.size() == 0) begin
        check_eq("sb_pending", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("sb_single_data_ok", {31'd0, inst_sram_data_ok && data_sram_data_ok}, 32'd0);
        check_eq("sb_owner", {31'd0, data_sram_data_ok}, {31'd0, e.owner_data});
        if (e.is_read)
          check_eq("sb_rdata", data_sram_data_ok ? data_sram_rdata : inst_sram_rdata, e.rdata);
        $display("txn done: owner=%s %s rdata=0x%08h",
                 data_sram_data_ok ? "data" : "inst", e.is_read ? "read" : "write",
                 data_sram_data_ok ? data_sram_rdata : inst_sram_rdata);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic data_request(input logic wr, input logic [31:0] addr,
                              input logic [3:0] strb, input logic [31:0] wd);
    data_sram_req   = 1'b1;
    data_sram_wr    = wr;
    data_sram_size  = 2'd2;
    data_sram_addr  = addr;
    data_sram_wstrb = strb;
    data_sram_wdata = wd;
  endtask

  task automatic inst_request(input logic [31:0] addr);
    inst_sram_req   = 1'b1;
    inst_sram_wr    = 1'b0;
    inst_sram_size  = 2'd2;
    inst_sram_addr  = addr;
    inst_sram_wstrb = 4'd0;
    inst_sram_wdata = 32'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 0; inst_sram_wstrb = 0;
    inst_sram_addr = 0; inst_sram_wdata = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 0; data_sram_wstrb = 0;
    data_sram_addr = 0; data_sram_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;

    // ---------------- reset state
    repeat (3) next_cycle();
    mid();
    check_eq("rst_arvalid", {31'd0, arvalid}, 32'd0);
    check_eq("rst_awvalid", {31'd0, awvalid}, 32'd0);
    check_eq("rst_wvalid", {31'd0, wvalid}, 32'd0);
    check_eq("rst_rready", {31'd0, rready}, 32'd0);
    check_eq("rst_bready", {31'd0, bready}, 32'd0);
    check_eq("rst_data_ok", {30'd0, inst_sram_data_ok, data_sram_data_ok}, 32'd0);
    check_eq("rst_araddr", araddr, 32'd0);
    next_cycle();
    reset = 1'b0;

    // ---------------- data read, minimum latency
    next_cycle();
    data_request(1'b0, 32'h1C000104, 4'h0, 32'h0);
    arready = 1'b1;
    mid();
    check_eq("rd_data_addr_ok", {31'd0, data_sram_addr_ok}, 32'd1);
    check_eq("rd_inst_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
    sb.push_back('{1'b1, 1'b1, 32'hDEADBEEF});
    next_cycle();
    data_sram_req = 1'b0;
    mid();
    check_eq("rd_arvalid", {31'd0, arvalid}, 32'd1);
    check_eq("rd_arid", {28'd0, arid}, 32'd1);
    check_eq("rd_araddr", araddr, 32'h1C000104);
    check_eq("rd_arsize", {29'd0, arsize}, 32'd2);
    next_cycle();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'hDEADBEEF;
    mid();
    check_eq("rd_data_ok", {31'd0, data_sram_data_ok}, 32'd1);
    check_eq("rd_inst_data_ok", {31'd0, inst_sram_data_ok}, 32'd0);
    check_eq("rd_rready", {31'd0, rready}, 32'd1);
    next_cycle();
    rvalid = 1'b0;
    mid();
    check_eq("rd_idle_rready", {31'd0, rready}, 32'd0);

    // ---------------- simultaneous requests: data write wins
    next_cycle();
    inst_request(32'h1C000000);
    data_request(1'b1, 32'h00000008, 4'b0011, 32'h0000ABCD);
    mid();
    check_eq("sim_data_addr_ok", {31'd0, data_sram_addr_ok}, 32'd1);
    check_eq("sim_inst_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
    sb.push_back('{1'b1, 1'b0, 32'h0});
    next_cycle();
    data_sram_req = 1'b0;
    awready = 1'b1; wready = 1'b1;
    mid();
    check_eq("sim_awvalid", {31'd0, awvalid}, 32'd1);
    check_eq("sim_wvalid", {31'd0, wvalid}, 32'd1);
    check_eq("sim_awaddr", awaddr, 32'h8);
    check_eq("sim_awid", {28'd0, awid}, 32'd1);
    check_eq("sim_wdata", wdata, 32'h0000ABCD);
    check_eq("sim_wstrb", {28'd0, wstrb}, 32'h3);
    check_eq("sim_busy_inst_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
    next_cycle();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
    mid();
    check_eq("sim_bready", {31'd0, bready}, 32'd1);
    check_eq("sim_data_ok", {31'd0, data_sram_data_ok}, 32'd1);
    check_eq("sim_resp_inst_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
    next_cycle();
    bvalid = 1'b0;
    mid();
    check_eq("sim_inst_grant", {31'd0, inst_sram_addr_ok}, 32'd1);
    sb.push_back('{1'b0, 1'b1, 32'h12345678});
    next_cycle();
    inst_sram_req = 1'b0;
    arready = 1'b1;
    mid();
    check_eq("sim_inst_arvalid", {31'd0, arvalid}, 32'd1);
    check_eq("sim_inst_arid", {28'd0, arid}, 32'd0);
    check_eq("sim_inst_araddr", araddr, 32'h1C000000);
    next_cycle();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h12345678;
    mid();
    check_eq("sim_inst_data_ok", {31'd0, inst_sram_data_ok}, 32'd1);
    next_cycle();
    rvalid = 1'b0;

    // ---------------- split write handshake
    next_cycle(); // cycle 0
    data_request(1'b1, 32'h1C000200, 4'hF, 32'hCAFEF00D);
    mid();
    check_eq("spl_addr_ok", {31'd0, data_sram_addr_ok}, 32'd1);
    sb.push_back('{1'b1, 1'b0, 32'h0});
    next_cycle(); // cycle 1
    data_sram_req = 1'b0; awready = 1'b1;
    mid();
    check_eq("spl_c1_awvalid", {31'd0, awvalid}, 32'd1);
    check_eq("spl_c1_wvalid", {31'd0, wvalid}, 32'd1);
    next_cycle(); // cycle 2
    awready = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      if (c == 4) wready = 1'b1;
      mid();
      check_eq($sformatf("spl_c%0d_awvalid", c), {31'd0, awvalid}, 32'd0);
      check_eq($sformatf("spl_c%0d_wvalid", c), {31'd0, wvalid}, 32'd1);
      check_eq($sformatf("spl_c%0d_bready", c), {31'd0, bready}, 32'd0);
      next_cycle();
    end
    wready = 1'b0; // cycle 5
    for (int c = 5; c <= 6; c++) begin
      mid();
      check_eq($sformatf("spl_c%0d_wvalid", c), {31'd0, wvalid}, 32'd0);
      check_eq($sformatf("spl_c%0d_bready", c), {31'd0, bready}, 32'd1);
      check_eq($sformatf("spl_c%0d_data_ok", c), {31'd0, data_sram_data_ok}, 32'd0);
      next_cycle();
    end
    bvalid = 1'b1; // cycle 7
    mid();
    check_eq("spl_c7_data_ok", {31'd0, data_sram_data_ok}, 32'd1);
    next_cycle();
    bvalid = 1'b0;

    // ---------------- read backpressure
    next_cycle();
    data_request(1'b0, 32'h1C000300, 4'h0, 32'h0);
    mid();
    check_eq("bp_addr_ok", {31'd0, data_sram_addr_ok}, 32'd1);
    sb.push_back('{1'b1, 1'b1, 32'h0BADF00D});
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      data_request(1'b0, 32'h1C000300 + 32'(c * 16), 4'h0, 32'h0);
      inst_request(32'h1C000040);
      mid();
      check_eq($sformatf("bp_c%0d_arvalid", c), {31'd0, arvalid}, 32'd1);
      check_eq($sformatf("bp_c%0d_araddr", c), araddr, 32'h1C000300);
      check_eq($sformatf("bp_c%0d_addr_ok", c),
               {30'd0, inst_sram_addr_ok, data_sram_addr_ok}, 32'd0);
    end
    next_cycle();
    data_sram_req = 1'b0; inst_sram_req = 1'b0; arready = 1'b1;
    mid();
    check_eq("bp_arvalid_hs", {31'd0, arvalid}, 32'd1);
    next_cycle();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h0BADF00D;
    mid();
    check_eq("bp_data_ok", {31'd0, data_sram_data_ok}, 32'd1);
    next_cycle();
    rvalid = 1'b0;

    // ---------------- reset during RD_DATA
    next_cycle();
    data_request(1'b0, 32'h1C000400, 4'h0, 32'h0);
    arready = 1'b1;
    mid();
    check_eq("rr_addr_ok", {31'd0, data_sram_addr_ok}, 32'd1);
    sb.push_back('{1'b1, 1'b1, 32'h55AA55AA});
    next_cycle();
    data_sram_req = 1'b0;
    next_cycle();
    arready = 1'b0;
    #1;
    check_eq("rr_rready_before", {31'd0, rready}, 32'd1);
    reset = 1'b1;
    rvalid = 1'b1; rdata = 32'h55AA55AA;
    #1;
    check_eq("rr_rready", {31'd0, rready}, 32'd0);
    check_eq("rr_valids", {29'd0, arvalid, awvalid, wvalid}, 32'd0);
    check_eq("rr_data_ok", {30'd0, inst_sram_data_ok, data_sram_data_ok}, 32'd0);
    sb.delete();
    next_cycle();
    reset = 1'b0; rvalid = 1'b0;
    next_cycle();
    inst_request(32'h1C000010);
    arready = 1'b1;
    mid();
    check_eq("rr_inst_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
    sb.push_back('{1'b0, 1'b1, 32'h11223344});
    next_cycle();
    inst_sram_req = 1'b0;
    mid();
    check_eq("rr_inst_arvalid", {31'd0, arvalid}, 32'd1);
    check_eq("rr_inst_araddr", araddr, 32'h1C000010);
    next_cycle();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h11223344;
    mid();
    check_eq("rr_inst_data_ok", {31'd0, inst_sram_data_ok}, 32'd1);
    next_cycle();
    rvalid = 1'b0;
    repeat (2) next_cycle();

    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_axi_arbiter.md
# mem_axi_arbiter

- Shares one simplified AXI master port between the CPU's two sram-like requesters: the instruction-fetch port and the EXE-stage data port (req/wr/size/wstrb/addr/wdata/addr_ok/data_ok).
- Sits between the pipeline and the SoC AXI interconnect.
- Allows one outstanding transaction at a time.
- Data requests win over instruction requests.

## Interface
Parameters:
- none; AXI IDs and fixed field values are package constants.

Ports:
- clk  in  1  core clock; one clock domain
- reset  in  1  asynchronous, active-high reset
- inst_sram_req / inst_sram_wr  in  1 / 1  instruction request; wr is always 0 in practice but is honoured
- inst_sram_size  in  2  0=byte, 1=half, 2=word
- inst_sram_wstrb / inst_sram_addr / inst_sram_wdata  in  4 / 32 / 32  request payload
- inst_sram_addr_ok / inst_sram_data_ok  out  1 / 1  accept pulse / completion pulse
- inst_sram_rdata  out  32  read data, valid with data_ok
- data_sram_*  same nine signals as inst_sram_*, for the data requester
- arid / araddr / arsize / arvalid  out  4 / 32 / 3 / 1  read address channel
- arready  in  1
- rid / rdata / rvalid  in  4 / 32 / 1; rready  out  1  read data channel; rresp and rlast are ignored
- awid / awaddr / awsize / awvalid  out  4 / 32 / 3 / 1; awready  in  1
- wdata / wstrb / wvalid  out  32 / 4 / 1; wready  in  1; wid=1, wlast=1 constant
- bvalid  in  1; bready  out  1; bid and bresp are ignored
- Constant outputs: arlen=awlen=0, arburst=awburst=2'b01, lock=cache=prot=0

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP.
- IDLE
  - grant = data_sram_req ? DATA : inst_sram_req ? INST : none.
  - The granted port's addr_ok = 1, combinationally, in the same cycle.
  - The losing port's addr_ok = 0; it must hold req.
  - On grant, latch owner, wr, size, addr, wstrb and wdata.
  - Next state: RD_ADDR if wr=0, else WR_ADDR_DATA.
- RD_ADDR
  - arvalid = 1, araddr = latched addr, arsize = {1'b0,size}.
  - arid = 0 for INST, 1 for DATA.
  - Go to RD_DATA on arvalid & arready.
- RD_DATA
  - rready = 1.
  - On rvalid: the owner's data_ok = 1 and rdata = rdata (both combinational); go to IDLE.
- WR_ADDR_DATA
  - awvalid and wvalid are both asserted on entry.
  - Each channel drops independently after its own handshake (per-channel done flags).
  - awid = 1; wdata and wstrb are the latched values.
  - Go to WR_RESP when both channels are done, including same-cycle completion.
- WR_RESP
  - bready = 1.
  - On bvalid: the owner's data_ok = 1; go to IDLE.
- The non-owner's data_ok is always 0. The owner's rdata is don't-care outside data_ok.
- Requests with size=3 are illegal and not checked.

## Timing
- Reset values:
  - state = IDLE.
  - arvalid, awvalid, wvalid, rready, bready = 0.
  - Both addr_ok and both data_ok = 0.
  - Latched payload = 0.
  - Done flags = 0.
- Reset asserted mid-transaction aborts it immediately. No data_ok is produced; the AXI slave shares the same reset.
- Valid and address outputs are registered.
  - arvalid/awvalid/wvalid rise the cycle after addr_ok.
  - They hold stable until their handshake.
- addr_ok is combinational from req and state, with no req→addr_ok path through AXI inputs. data_ok is combinational from rvalid/bvalid.
- Minimum read: addr_ok at cycle 0, arvalid at 1 (arready=1), rvalid at 2 with data_ok at 2, IDLE at 3. The next addr_ok is possible at cycle 3.
- Minimum write: addr_ok at 0, aw/w handshake at 1, bvalid and data_ok at 2.
- addr_ok is never asserted outside IDLE, so at most one outstanding request.
- A new request arriving in the cycle data_ok fires is not accepted until the next cycle (IDLE).
- Simultaneous inst and data req in IDLE: data wins every time. Inst starvation is accepted by design; the pipeline stalls fetch behind memory operations anyway.

## Structure
- Package mem_axi_pkg holds:
  - state enum;
  - ID_INST=4'd0, ID_DATA=4'd1;
  - BURST_INCR=2'b01;
  - owner encoding.
- Single module. No sub-module is natural, because the FSM and the latch register are tightly coupled.

## Test plan
- **Data read:** data req wr=0 addr=0x1C000104 size=2, slave arready=1, rvalid two cycles later with rdata=0xDEADBEEF.
  - Data addr_ok at cycle 0; arid=1, araddr=0x1C000104, arsize=2 at cycle 1; data_ok with rdata=0xDEADBEEF; inst data_ok stays 0.
- **Simultaneous requests:** inst req and data req (write, addr=0x8, wstrb=4'b0011, wdata=0x0000ABCD) both high at cycle 0.
  - Data addr_ok=1 and inst addr_ok=0.
  - After bvalid, data_ok pulses; inst addr_ok is granted the following cycle.
- **Split write handshake:** awready at cycle 1, wready delayed to cycle 4.
  - awvalid drops after cycle 1; wvalid holds until cycle 4; WR_RESP is entered at cycle 5.
  - bvalid at cycle 7 gives data_ok at cycle 7.
- **Read backpressure:** arready low for 5 cycles.
  - arvalid and araddr stay stable; no addr_ok to either port during the wait.
- **Reset mid-transaction:** reset asserted while in RD_DATA.
  - All valid/ready outputs and data_ok go to 0 immediately (async); state returns to IDLE.
  - After reset release, an inst read completes normally.
